// File: rtl/posit_unpack_if.sv
// Handshake and data bundle for posit_unpack: operand word in, decoded lanes out.
// slave is the decoder's view, master is the operand source / consumer view.
interface posit_unpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_pre;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_pre;
    logic [3:0]  out_sign;
    logic [3:0]  out_zero;
    logic [3:0]  out_nar;
    logic [19:0] out_exp;
    logic [31:0] out_mant;

    modport slave (
        input  in_valid, in_pre, in_word, out_ready,
        output in_ready, out_valid, out_pre, out_sign, out_zero, out_nar, out_exp, out_mant
    );

    modport master (
        output in_valid, in_pre, in_word, out_ready,
        input  in_ready, out_valid, out_pre, out_sign, out_zero, out_nar, out_exp, out_mant
    );
endinterface

// File: rtl/posit_unpack.sv
// Multi-precision posit decoder (4x posit8 / 2x posit16 / 1x posit32) with valid/ready pipeline.
// POSIT_UNPACK_IN_REG_EN adds an input register stage ahead of decode (latency 2 instead of 1).

module posit_lane_dec #(
    parameter int N  = 8,
    parameter int ES = 0,
    parameter int EW = 5
) (
    input  logic [N-1:0]  p,
    output logic          sign,
    output logic          zero,
    output logic          nar,
    output logic [EW-1:0] exp_o,
    output logic [N-1:0]  mant
);
    always_comb begin
        logic [N-1:0]  mag;
        logic [N-1:0]  body;
        logic [N-1:0]  frac;
        logic [EW-1:0] k;
        logic [5:0]    m;
        logic [2:0]    e;
        logic          r;
        logic          run;

        sign  = 1'b0;
        zero  = 1'b0;
        nar   = 1'b0;
        exp_o = '0;
        mant  = '0;

        mag = p[N-1] ? -p : p;
        r   = mag[N-2];
        run = 1'b1;
        m   = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (mag[i] == r)) m = m + 6'd1;
            else                      run = 1'b0;
        end
        // Drop sign, regime run and terminator; shifts past the lane fill with zeros.
        body = mag << (m + 6'd2);
        e    = 3'(body >> (N - ES));
        frac = body << ES;
        k    = r ? (EW'(m) - EW'(1)) : (EW'(0) - EW'(m));

        if (p == '0) begin
            zero = 1'b1;
        end else if (p == {1'b1, {(N-1){1'b0}}}) begin
            nar  = 1'b1;
            sign = 1'b1;
        end else begin
            sign  = p[N-1];
            exp_o = (k << ES) + EW'(e);
            mant  = {1'b1, (N-1)'(frac >> 1)};
        end
    end
endmodule

module posit_unpack (
    input  logic           clk,
    input  logic           rst,
    posit_unpack_if.slave  bus
);
    logic        rdy_b;
    logic        load_b;
    logic [1:0]  src_pre;
    logic [31:0] src_word;

    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_pre_q,   out_pre_d;
    logic [3:0]  out_sign_q,  out_sign_d;
    logic [3:0]  out_zero_q,  out_zero_d;
    logic [3:0]  out_nar_q,   out_nar_d;
    logic [19:0] out_exp_q,   out_exp_d;
    logic [31:0] out_mant_q,  out_mant_d;

    assign rdy_b = ~out_valid_q | bus.out_ready;

`ifdef POSIT_UNPACK_IN_REG_EN
    logic        va_q, va_d;
    logic [1:0]  pre_a_q, pre_a_d;
    logic [31:0] word_a_q, word_a_d;
    logic        rdy_a;

    always_comb begin
        rdy_a    = ~va_q | rdy_b;
        va_d     = va_q;
        pre_a_d  = pre_a_q;
        word_a_d = word_a_q;
        if (bus.in_valid && rdy_a) begin
            va_d     = 1'b1;
            pre_a_d  = bus.in_pre;
            word_a_d = bus.in_word;
        end else if (rdy_b) begin
            va_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_q     <= 1'b0;
            pre_a_q  <= '0;
            word_a_q <= '0;
        end else begin
            va_q     <= va_d;
            pre_a_q  <= pre_a_d;
            word_a_q <= word_a_d;
        end
    end

    assign bus.in_ready = rdy_a;
    assign load_b       = va_q & rdy_b;
    assign src_pre      = pre_a_q;
    assign src_word     = word_a_q;
`else
    assign bus.in_ready = rdy_b;
    assign load_b       = bus.in_valid & rdy_b;
    assign src_pre      = bus.in_pre;
    assign src_word     = bus.in_word;
`endif

    logic [3:0]       s8, z8, n8;
    logic [3:0][4:0]  e8;
    logic [3:0][7:0]  m8;
    logic [1:0]       s16, z16, n16;
    logic [1:0][9:0]  e16;
    logic [1:0][15:0] m16;
    logic             s32, z32, n32;
    logic [19:0]      e32;
    logic [31:0]      m32;

    for (genvar i = 0; i < 4; i++) begin : g_p8
        posit_lane_dec #(.N(8), .ES(0), .EW(5)) u_dec (
            .p(src_word[8*i +: 8]), .sign(s8[i]), .zero(z8[i]), .nar(n8[i]),
            .exp_o(e8[i]), .mant(m8[i])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_p16
        posit_lane_dec #(.N(16), .ES(1), .EW(10)) u_dec (
            .p(src_word[16*j +: 16]), .sign(s16[j]), .zero(z16[j]), .nar(n16[j]),
            .exp_o(e16[j]), .mant(m16[j])
        );
    end

    posit_lane_dec #(.N(32), .ES(2), .EW(20)) u_p32 (
        .p(src_word), .sign(s32), .zero(z32), .nar(n32), .exp_o(e32), .mant(m32)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_pre_d   = out_pre_q;
        out_sign_d  = out_sign_q;
        out_zero_d  = out_zero_q;
        out_nar_d   = out_nar_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        if (load_b) begin
            out_valid_d = 1'b1;
            out_pre_d   = src_pre;
            out_sign_d  = '0;
            out_zero_d  = '0;
            out_nar_d   = '0;
            out_exp_d   = '0;
            out_mant_d  = '0;
            unique case (src_pre)
                2'b00: begin
                    out_sign_d = s8;
                    out_zero_d = z8;
                    out_nar_d  = n8;
                    out_exp_d  = e8;
                    out_mant_d = m8;
                end
                // posit16 flags sit in the upper slot of each lane pair
                2'b01: begin
                    out_sign_d = {s16[1], 1'b0, s16[0], 1'b0};
                    out_zero_d = {z16[1], 1'b0, z16[0], 1'b0};
                    out_nar_d  = {n16[1], 1'b0, n16[0], 1'b0};
                    out_exp_d  = e16;
                    out_mant_d = m16;
                end
                2'b10: begin
                    out_sign_d = {s32, 3'b000};
                    out_zero_d = {z32, 3'b000};
                    out_nar_d  = {n32, 3'b000};
                    out_exp_d  = e32;
                    out_mant_d = m32;
                end
                default: out_zero_d = 4'hF;
            endcase
        end else if (rdy_b) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pre_q   <= '0;
            out_sign_q  <= '0;
            out_zero_q  <= '0;
            out_nar_q   <= '0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pre_q   <= out_pre_d;
            out_sign_q  <= out_sign_d;
            out_zero_q  <= out_zero_d;
            out_nar_q   <= out_nar_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pre   = out_pre_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_nar   = out_nar_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_mant  = out_mant_q;
endmodule

// File: tb/tb_posit_unpack.sv
// Scoreboard bench for posit_unpack: directed test-plan words, extremes, stall, random backpressure, mid-run reset.
module tb_posit_unpack;
    typedef struct packed {
        logic [1:0]  pre;
        logic [3:0]  sign;
        logic [3:0]  zero;
        logic [3:0]  nar;
        logic [19:0] ex;
        logic [31:0] mant;
    } res_t;

`ifdef POSIT_UNPACK_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic or_force = 1'b1;
    logic rnd_bp = 1'b0;
    logic rnd_val = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    res_t q[$];
    res_t mon_r;

    posit_unpack_if bus();
    posit_unpack dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    assign bus.out_ready = rnd_bp ? rnd_val : or_force;
    always @(posedge clk) begin
        #1;
        rnd_val = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input res_t e);
        chk({tag, "_pre"},  64'(bus.out_pre),  64'(e.pre));
        chk({tag, "_sign"}, 64'(bus.out_sign), 64'(e.sign));
        chk({tag, "_zero"}, 64'(bus.out_zero), 64'(e.zero));
        chk({tag, "_nar"},  64'(bus.out_nar),  64'(e.nar));
        chk({tag, "_exp"},  64'(bus.out_exp),  64'(e.ex));
        chk({tag, "_mant"}, 64'(bus.out_mant), 64'(e.mant));
    endtask

    // Reference lane decode: walk the bits of the magnitude one at a time.
    function automatic void lane(input int n, input int es, input logic [31:0] p_in,
                                 output logic s, output logic z, output logic na,
                                 output int ex, output logic [31:0] mt);
        logic [31:0] mask, p, v;
        int i, m, k, e, pos;
        logic r;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        p = p_in & mask;
        s = 1'b0; z = 1'b0; na = 1'b0; ex = 0; mt = '0;
        if (p == 32'h0) begin
            z = 1'b1;
        end else if (p == (32'h1 << (n - 1))) begin
            na = 1'b1;
            s  = 1'b1;
        end else begin
            s = p[n-1];
            v = s ? ((~p + 32'h1) & mask) : p;
            i = n - 2;
            r = v[i];
            m = 0;
            while (i >= 0 && v[i] == r) begin
                m++;
                i--;
            end
            k = r ? m - 1 : -m;
            i--;
            e = 0;
            for (int j = 0; j < es; j++) begin
                e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
                i--;
            end
            pos = n - 1;
            mt[pos] = 1'b1;
            pos--;
            while (i >= 0) begin
                mt[pos] = v[i];
                pos--;
                i--;
            end
            ex = k * (1 << es) + e;
        end
    endfunction

    function automatic res_t model(input logic [1:0] pre, input logic [31:0] w);
        res_t res;
        logic s, z, na;
        int ex;
        logic [31:0] mt;
        res = '0;
        res.pre = pre;
        case (pre)
            2'b00: for (int l = 0; l < 4; l++) begin
                lane(8, 0, w >> (8 * l), s, z, na, ex, mt);
                res.sign[l] = s; res.zero[l] = z; res.nar[l] = na;
                res.ex[5*l +: 5] = ex[4:0];
                res.mant[8*l +: 8] = mt[7:0];
            end
            2'b01: for (int j = 0; j < 2; j++) begin
                lane(16, 1, w >> (16 * j), s, z, na, ex, mt);
                res.sign[2*j+1] = s; res.zero[2*j+1] = z; res.nar[2*j+1] = na;
                res.ex[10*j +: 10] = ex[9:0];
                res.mant[16*j +: 16] = mt[15:0];
            end
            2'b10: begin
                lane(32, 2, w, s, z, na, ex, mt);
                res.sign[3] = s; res.zero[3] = z; res.nar[3] = na;
                res.ex = ex[19:0];
                res.mant = mt;
            end
            default: res.zero = 4'hF;
        endcase
        return res;
    endfunction

    function automatic res_t mk(input logic [1:0] pre, input logic [3:0] sg, input logic [3:0] zr,
                                input logic [3:0] nr, input logic [19:0] ex, input logic [31:0] mt);
        res_t r;
        r.pre = pre; r.sign = sg; r.zero = zr; r.nar = nr; r.ex = ex; r.mant = mt;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(bus.out_valid), 64'd0);
            end else if (bus.out_ready) begin
                mon_r = q.pop_front();
                cmp("out", mon_r);
            end else begin
                cmp("hold", q[0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [1:0] pre, input logic [31:0] w, input res_t e);
        int n;
        bus.in_valid = 1'b1;
        bus.in_pre   = pre;
        bus.in_word  = w;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) q.push_back(e);
        else chk("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [1:0] pre, input logic [31:0] w);
        send(pre, w, model(pre, w));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, idx;
        logic [31:0] sw [8];
        bus.in_valid = 1'b0;
        bus.in_pre   = 2'b00;
        bus.in_word  = '0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pre",   64'(bus.out_pre),   64'd0);
        chk("rst_out_flags", 64'({bus.out_sign, bus.out_zero, bus.out_nar}), 64'd0);
        chk("rst_out_exp",   64'(bus.out_exp),   64'd0);
        chk("rst_out_mant",  64'(bus.out_mant),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        send(2'b10, 32'h4000_0000, mk(2'b10, 4'b0000, 4'b0000, 4'b0000, 20'd0, 32'h8000_0000));
        send(2'b00, 32'h0080_40C0, mk(2'b00, 4'b0101, 4'b1000, 4'b0100, 20'd0, 32'h0000_8080));
        send(2'b01, 32'h7FFF_0001, mk(2'b01, 4'b0000, 4'b0000, 4'b0000, {10'd28, 10'h3E4}, 32'h8000_8000));
        send(2'b00, 32'h0000_0050, mk(2'b00, 4'b0000, 4'b1110, 4'b0000, 20'd0, 32'h0000_00C0));
        send(2'b11, 32'h1234_5678, mk(2'b11, 4'b0000, 4'b1111, 4'b0000, 20'd0, 32'h0));
        send_m(2'b00, 32'h7F01_FF81);
        send_m(2'b01, 32'h8001_7FFE);
        send_m(2'b10, 32'h7FFF_FFFF);
        send_m(2'b10, 32'h0000_0001);
        send_m(2'b10, 32'h8000_0000);
        send_m(2'b10, 32'hC3A5_0F11);
        send_m(2'b01, 32'h0000_8000);
        drain();

        send_m(2'b00, 32'h5A3C_6B7E);
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
        end
        chk("latency", 64'(cyc + 1 - 1), 64'(LAT));
        drain();

        for (int i = 0; i < 8; i++) sw[i] = $urandom;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 60) begin
            or_force = !(cyc >= 3 && cyc <= 5);
            bus.in_valid = 1'b1;
            bus.in_pre   = 2'b00;
            bus.in_word  = sw[idx];
            @(negedge clk);
            if (cyc == 5) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.in_ready) begin
                q.push_back(model(2'b00, sw[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        or_force = 1'b1;
        chk("stream_count", 64'(idx), 64'd8);
        drain();

        rnd_bp = 1'b1;
        for (int i = 0; i < 60; i++) send_m(2'($urandom_range(0, 3)), $urandom);
        rnd_bp = 1'b0;
        drain();

        or_force = 1'b0;
        repeat (3) begin
            bus.in_valid = 1'b1;
            bus.in_pre   = 2'b10;
            bus.in_word  = $urandom;
            @(negedge clk);
            if (bus.in_ready) q.push_back(model(bus.in_pre, bus.in_word));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst_mant",      64'(bus.out_mant),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        or_force = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
        send_m(2'b01, 32'h3C01_C3FF);
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
        end
        chk("post_rst_latency", 64'(cyc), 64'(LAT));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/posit_unpack.md
# posit_unpack

Multi-precision posit decoder feeding the FMA datapath: accepts one packed 32-bit word holding four posit8 (es=0), two posit16 (es=1) or one posit32 (es=2) operands and splits each lane into sign, signed scaled exponent and normalized significand. It is the inverse of the packing/rounding stage at the FMA output and sits between the operand source and the multiplier front end. It uses the same `in_pre` mode encoding and lane/flag slot layout as the packing stage, and adds a valid/ready pipeline with backpressure.

## Interface
Parameters: none (widths fixed by the 32-bit multi-precision format).

- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- in_pre  in  2  00: 4×posit8, 01: 2×posit16, 10: 1×posit32, 11: reserved
- in_word  in  32  packed posits; lane i at [8i+7:8i] / [16j+15:16j] / [31:0]
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts result
- out_pre  out  2  in_pre of this result
- out_sign  out  4  sign per flag slot
- out_zero  out  4  lane is zero
- out_nar  out  4  lane is NaR
- out_exp  out  20  signed scaled exponent k·2^es+e; mode 00: 4×5 bits at [5i+4:5i]; 01: 2×10 at [9:0], [19:10]; 10: 20 at [19:0]
- out_mant  out  32  significand, hidden bit at lane MSB, fraction left-aligned, zero-padded; lane layout as in_word

## Operation
- Flag slots: mode 00 uses slots 0..3 for lanes 0..3; mode 01 uses slot 1 (low half) and slot 3 (high half), slots 0 and 2 driven 0; mode 10 uses slot 3, slots 0..2 driven 0.
- Per n-bit lane p: p==0 → zero=1, sign=0, exp=0, mant=0. p==1 followed by n-1 zeros → nar=1, sign=1, exp=0, mant=0.
- Otherwise: sign=p[n-1]; mag = sign ? (−p mod 2^n) : p. Regime = run of equal bits after the sign bit in mag, length m, run bit r. k = r ? m−1 : −m. Skip the terminating bit (absent when the run reaches the LSB). Next es bits form e; missing bits read as 0. Remaining bits form the fraction.
- Exponent ranges: posit8 −6..6 (5b), posit16 −28..28 (10b), posit32 −120..120 (20b). All are two's complement and never overflow.
- Mantissa widths: hidden plus fraction occupy at most 6/13/28 bits of the 8/16/32 lane; the remainder is zero.
- in_pre=11: all slots zero=1, nar=0, sign=0, exp=0, mant=0; out_pre=11 is passed through.

## Timing
- Two-stage pipeline. Stage A registers in_pre/in_word plus a valid bit. Stage B registers the decoded outputs plus out_valid.
- Latency: 2 cycles from the accepting in_valid&in_ready edge to out_valid.
- Stall: rdyB = ~out_valid | out_ready; rdyA = ~vA | rdyB; in_ready = rdyA. This is a combinational path from out_ready, by design.
- Stage A loads when in_valid&rdyA. vA clears when stage A is drained into B and there is no new input.
- Full throughput: one word per cycle while out_ready=1.
- out_* data is held stable while out_valid&~out_ready.
- Every accepted word produces exactly one result, in order.
- Reset, including mid-operation: vA=0, out_valid=0, all data registers 0 (out_pre=00, out_sign/zero/nar=0, out_exp=0, out_mant=0). In-flight words are discarded. in_ready=1 from the first cycle after reset.

## Configuration
- POSIT_UNPACK_IN_REG_EN defined: the two-stage pipeline above, latency 2, and the run-length count is cut by the stage A register.
- Not defined: stage A is removed and decode is combinational from in_word into the stage B registers. Latency is 1, in_ready = rdyB. Handshake rules are otherwise identical.

## Test plan
- Mode 10, in_word=0x40000000 → slot3 sign0, exp 0, mant 0x80000000, zero/nar 0, all other slots 0.
- Mode 00, in_word=0x008040C0 → lane0 sign1/exp0/mant 0x80; lane1 sign0/exp0/mant 0x80; nar=4'b0100; zero=4'b1000.
- Mode 01, in_word=0x7FFF0001 → out_exp[19:10]=28, out_exp[9:0]=0x3E4 (−28), both mant halves 0x8000, sign=0.
- Mode 00, in_word=0x00000050 → lane0 exp 0, mant 0xC0 (1.5); lanes 1..3 zero=1.
- Stream 8 words with in_valid held high and out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full, out_* are held, all 8 results arrive in order with no duplicates.
- Assert rst while both stages are valid → out_valid=0 and in_ready=1 next cycle, no stale result emitted; repeat with POSIT_UNPACK_IN_REG_EN undefined and confirm latency 1.
